// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO on a registered-read dual-port RAM with occupancy count, sticky
// error flags and an optional first-word-fall-through output stage.
module fifo_sync_flex #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 256,
  parameter int MAKE_FWFT = 0
) (
  input  logic                     i_Rst_L,
  input  logic                     i_Clk,
  input  logic                     i_Wr_DV,
  input  logic [WIDTH-1:0]         i_Wr_Data,
  input  logic [$clog2(DEPTH)-1:0] i_AF_Level,
  output logic                     o_AF_Flag,
  output logic                     o_Full,
  input  logic                     i_Rd_En,
  output logic [WIDTH-1:0]         o_Rd_Data,
  output logic                     o_Rd_DV,
  input  logic [$clog2(DEPTH)-1:0] i_AE_Level,
  output logic                     o_AE_Flag,
  output logic                     o_Empty,
  output logic [$clog2(DEPTH):0]   o_Count,
  input  logic                     i_Clr_Err,
  output logic                     o_Overflow,
  output logic                     o_Underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic             wr_ok;
  logic             rd_ok;
  logic [CW-1:0]    count_next;

  // No pass-through: acceptance looks only at the registered full/empty state.
  assign wr_ok = i_Wr_DV & ~o_Full;
  assign rd_ok = i_Rd_En & ~o_Empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    count_next = o_Count;
    if (wr_ok && !rd_ok)      count_next = o_Count + CW'(1);
    else if (rd_ok && !wr_ok) count_next = o_Count - CW'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Count     <= '0;
      o_Full      <= 1'b0;
      o_AF_Flag   <= 1'b0;
      o_AE_Flag   <= 1'b1;
      wr_ptr      <= '0;
      o_Overflow  <= 1'b0;
      o_Underflow <= 1'b0;
    end else begin
      o_Count     <= count_next;
      o_Full      <= (count_next == CW'(DEPTH));
      o_AF_Flag   <= ((CW'(DEPTH) - count_next) < {1'b0, i_AF_Level});
      o_AE_Flag   <= (count_next <= {1'b0, i_AE_Level});
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      o_Overflow  <= (i_Wr_DV & o_Full)  | (o_Overflow  & ~i_Clr_Err);
      o_Underflow <= (i_Rd_En & o_Empty) | (o_Underflow & ~i_Clr_Err);
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; stale contents are never exposed.
  always_ff @(posedge i_Clk) begin
    if (wr_ok) mem[wr_ptr] <= i_Wr_Data;
  end

  if (MAKE_FWFT == 0) begin : g_std
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        rd_ptr    <= '0;
        o_Rd_Data <= '0;
        o_Rd_DV   <= 1'b0;
        o_Empty   <= 1'b1;
      end else begin
        o_Empty <= (count_next == '0);
        o_Rd_DV <= rd_ok;
        if (rd_ok) begin
          o_Rd_Data <= mem[rd_ptr];
          rd_ptr    <= rd_ptr + AW'(1);
        end
      end
    end
  end else begin : g_fwft
    // o_Rd_Data is the head slot; skid holds the second word; ram_q is a read in flight.
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] ram_q;
    logic [WIDTH-1:0] skid;
    logic [WIDTH-1:0] head_n;
    logic [WIDTH-1:0] skid_n;
    logic [1:0]       stage_cnt;
    logic [1:0]       stage_n;
    logic             pend;
    logic             issue;
    logic [CW-1:0]    ram_words;

    assign ram_words = o_Count - CW'(stage_cnt) - CW'(pend);

    always_comb begin
      head_n  = o_Rd_Data;
      skid_n  = skid;
      stage_n = stage_cnt;
      if (rd_ok) begin
        stage_n = stage_cnt - 2'd1;
        if (stage_cnt == 2'd2) head_n = skid;
      end
      if (pend) begin
        if (stage_n == 2'd0) head_n = ram_q;
        else                 skid_n = ram_q;
        stage_n = stage_n + 2'd1;
      end
      // Prefetch only when the landing word is guaranteed a free slot next edge.
      issue = (ram_words != '0) && (stage_n <= 2'd1);
    end

    always_ff @(posedge i_Clk) begin
      if (issue) ram_q <= mem[rd_ptr];
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        rd_ptr    <= '0;
        skid      <= '0;
        stage_cnt <= 2'd0;
        pend      <= 1'b0;
        o_Rd_Data <= '0;
        o_Rd_DV   <= 1'b0;
        o_Empty   <= 1'b1;
      end else begin
        o_Rd_Data <= head_n;
        skid      <= skid_n;
        stage_cnt <= stage_n;
        pend      <= issue;
        if (issue) rd_ptr <= rd_ptr + AW'(1);
        o_Empty   <= (stage_n == 2'd0);
        o_Rd_DV   <= (stage_n != 2'd0);
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Drives a standard DEPTH=256 FIFO and a FWFT DEPTH=4 FIFO with shared stimulus and
// checks both against a queue-based reference model through a negedge monitor.
module tb_fifo_sync_flex;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_dv, rd_en, clr_err;
  logic [7:0] wr_data;
  logic [7:0] af_lvl_s, ae_lvl_s;
  logic [1:0] af_lvl_f, ae_lvl_f;

  logic       s_af, s_full, s_rd_dv, s_ae, s_empty, s_ovf, s_unf;
  logic [7:0] s_rd_data;
  logic [8:0] s_count;
  logic       f_af, f_full, f_rd_dv, f_ae, f_empty, f_ovf, f_unf;
  logic [7:0] f_rd_data;
  logic [2:0] f_count;

  always #5 clk = ~clk;

  fifo_sync_flex #(.WIDTH(8), .DEPTH(256), .MAKE_FWFT(0)) u_std (
    .i_Rst_L(rst_n), .i_Clk(clk), .i_Wr_DV(wr_dv), .i_Wr_Data(wr_data),
    .i_AF_Level(af_lvl_s), .o_AF_Flag(s_af), .o_Full(s_full), .i_Rd_En(rd_en),
    .o_Rd_Data(s_rd_data), .o_Rd_DV(s_rd_dv), .i_AE_Level(ae_lvl_s), .o_AE_Flag(s_ae),
    .o_Empty(s_empty), .o_Count(s_count), .i_Clr_Err(clr_err),
    .o_Overflow(s_ovf), .o_Underflow(s_unf)
  );

  fifo_sync_flex #(.WIDTH(8), .DEPTH(4), .MAKE_FWFT(1)) u_fw (
    .i_Rst_L(rst_n), .i_Clk(clk), .i_Wr_DV(wr_dv), .i_Wr_Data(wr_data),
    .i_AF_Level(af_lvl_f), .o_AF_Flag(f_af), .o_Full(f_full), .i_Rd_En(rd_en),
    .o_Rd_Data(f_rd_data), .o_Rd_DV(f_rd_dv), .i_AE_Level(ae_lvl_f), .o_AE_Flag(f_ae),
    .o_Empty(f_empty), .o_Count(f_count), .i_Clr_Err(clr_err),
    .o_Overflow(f_ovf), .o_Underflow(f_unf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each stored word remembers the edge that wrote it.
  typedef struct {
    logic [7:0] data;
    int         wedge;
  } entry_t;

  entry_t     q_s[$];
  entry_t     q_f[$];
  logic [7:0] exp_s[$];
  int         edge_num = 0;
  bit m_ovf_s, m_unf_s, m_af_s, m_ae_s;
  bit m_ovf_f, m_unf_f, m_af_f, m_ae_f;

  // A FWFT word is presentable once it is the oldest and two edges have passed since its write.
  function automatic bit fw_visible(input int e);
    if (q_f.size() == 0) return 1'b0;
    return e >= q_f[0].wedge + 2;
  endfunction

  task automatic model_reset();
    q_s.delete(); q_f.delete(); exp_s.delete();
    m_ovf_s = 0; m_unf_s = 0; m_af_s = 0; m_ae_s = 1;
    m_ovf_f = 0; m_unf_f = 0; m_af_f = 0; m_ae_f = 1;
  endtask

  task automatic model_step();
    bit s_full_m, s_empty_m, f_full_m, f_empty_m;
    entry_t e;
    s_full_m  = (q_s.size() == 256);
    s_empty_m = (q_s.size() == 0);
    f_full_m  = (q_f.size() == 4);
    f_empty_m = !fw_visible(edge_num);
    edge_num++;

    m_ovf_s = (wr_dv && s_full_m)  || (m_ovf_s && !clr_err);
    m_unf_s = (rd_en && s_empty_m) || (m_unf_s && !clr_err);
    if (rd_en && !s_empty_m) begin
      e = q_s.pop_front();
      exp_s.push_back(e.data);
    end
    if (wr_dv && !s_full_m) q_s.push_back('{wr_data, edge_num});
    m_af_s = (256 - q_s.size()) < int'(af_lvl_s);
    m_ae_s = q_s.size() <= int'(ae_lvl_s);

    m_ovf_f = (wr_dv && f_full_m)  || (m_ovf_f && !clr_err);
    m_unf_f = (rd_en && f_empty_m) || (m_unf_f && !clr_err);
    if (rd_en && !f_empty_m) void'(q_f.pop_front());
    if (wr_dv && !f_full_m) q_f.push_back('{wr_data, edge_num});
    m_af_f = (4 - q_f.size()) < int'(af_lvl_f);
    m_ae_f = q_f.size() <= int'(ae_lvl_f);
  endtask

  // Apply one cycle of stimulus: inputs change 1 time unit after the rising edge.
  task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit c);
    wr_dv = w; wr_data = d; rd_en = r; clr_err = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Monitor: compares every output against the model away from the active edge.
  bit vis;
  always @(negedge clk) begin
    if (rst_n) begin
      check("s_count", int'(s_count), q_s.size());
      check("s_full", int'(s_full), int'(q_s.size() == 256));
      check("s_empty", int'(s_empty), int'(q_s.size() == 0));
      check("s_af", int'(s_af), int'(m_af_s));
      check("s_ae", int'(s_ae), int'(m_ae_s));
      check("s_ovf", int'(s_ovf), int'(m_ovf_s));
      check("s_unf", int'(s_unf), int'(m_unf_s));
      if (exp_s.size() != 0) begin
        check("s_rd_dv", int'(s_rd_dv), 1);
        check("s_rd_data", int'(s_rd_data), int'(exp_s.pop_front()));
      end else begin
        check("s_rd_dv", int'(s_rd_dv), 0);
      end

      vis = fw_visible(edge_num);
      check("f_count", int'(f_count), q_f.size());
      check("f_full", int'(f_full), int'(q_f.size() == 4));
      check("f_empty", int'(f_empty), int'(!vis));
      check("f_rd_dv", int'(f_rd_dv), int'(vis));
      if (vis) check("f_rd_data", int'(f_rd_data), int'(q_f[0].data));
      check("f_af", int'(f_af), int'(m_af_f));
      check("f_ae", int'(f_ae), int'(m_ae_f));
      check("f_ovf", int'(f_ovf), int'(m_ovf_f));
      check("f_unf", int'(f_unf), int'(m_unf_f));
    end
  end

  initial begin
    rst_n = 1'b0; wr_dv = 0; rd_en = 0; clr_err = 0; wr_data = '0;
    af_lvl_s = 8'd10; ae_lvl_s = 8'd10; af_lvl_f = 2'd1; ae_lvl_f = 2'd1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_s_empty", int'(s_empty), 1);
    check("rst_s_ae", int'(s_ae), 1);
    check("rst_f_empty", int'(f_empty), 1);

    // Single word through the standard FIFO
    cyc(1, 8'hA1, 0, 0);
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 1, 0);
    check("t1_rd_dv", int'(s_rd_dv), 1);
    check("t1_rd_data", int'(s_rd_data), 8'hA1);
    check("t1_count", int'(s_count), 0);
    check("t1_empty", int'(s_empty), 1);
    check("t1_full", int'(s_full), 0);
    cyc(0, 8'h00, 0, 0);
    check("t1_rd_dv_pulse", int'(s_rd_dv), 0);

    // Fill to DEPTH with threshold crossings
    for (int i = 0; i < 256; i++) begin
      cyc(1, 8'($urandom), 0, 0);
      if (i == 9)   check("t2_ae_at_10", int'(s_ae), 1);
      if (i == 10)  check("t2_ae_at_11", int'(s_ae), 0);
      if (i == 245) check("t2_af_at_246", int'(s_af), 0);
      if (i == 246) check("t2_af_at_247", int'(s_af), 1);
    end
    check("t2_full", int'(s_full), 1);
    check("t2_count", int'(s_count), 256);

    // Overflow, set-beats-clear, drain in order, clear
    cyc(1, 8'h55, 0, 0);
    check("t3_ovf", int'(s_ovf), 1);
    check("t3_count", int'(s_count), 256);
    cyc(1, 8'h55, 0, 1);
    check("t3_ovf_set_wins", int'(s_ovf), 1);
    for (int i = 0; i < 256; i++) cyc(0, 8'h00, 1, 0);
    check("t3_empty", int'(s_empty), 1);
    cyc(0, 8'h00, 0, 1);
    check("t3_ovf_clr", int'(s_ovf), 0);

    // Underflow, then continuous write+read from empty
    cyc(0, 8'h00, 1, 0);
    check("t4_unf", int'(s_unf), 1);
    check("t4_rd_dv", int'(s_rd_dv), 0);
    for (int i = 0; i < 10; i++) cyc(1, 8'($urandom), 1, 0);
    check("t4_count", int'(s_count), 1);
    repeat (8) cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 1);

    // FWFT latency and sustained pops
    for (int i = 0; i < 4; i++) begin
      cyc(1, 8'(i + 1), 0, 0);
      if (i == 1) check("t5_empty_k1", int'(f_empty), 1);
      if (i == 2) check("t5_head_k2", int'(f_rd_data), 1);
    end
    check("t5_full", int'(f_full), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 1, 0);
      if (i < 3) check("t5_pop_data", int'(f_rd_data), i + 2);
      else       check("t5_drained", int'(f_empty), 1);
    end

    // Randomised traffic: fill-biased then drain-biased
    for (int i = 0; i < 1600; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        af_lvl_s = 8'($urandom); ae_lvl_s = 8'($urandom);
        af_lvl_f = 2'($urandom); ae_lvl_f = 2'($urandom);
      end
      if (i < 800)
        cyc($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 35,
            $urandom_range(0, 99) < 3);
      else
        cyc($urandom_range(0, 99) < 35, 8'($urandom), $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 3);
    end

    // Asynchronous reset in the middle of a burst
    repeat (300) cyc(0, 8'h00, 1, 0);
    for (int i = 0; i < 100; i++) cyc(1, 8'($urandom_range(1, 255)), 0, 0);
    cyc(1, 8'h77, 1, 0);
    check("t7_count_100", int'(s_count), 100);
    wr_dv = 1'b1; rd_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("t7_s_count", int'(s_count), 0);
    check("t7_s_empty", int'(s_empty), 1);
    check("t7_s_full", int'(s_full), 0);
    check("t7_s_af", int'(s_af), 0);
    check("t7_s_ae", int'(s_ae), 1);
    check("t7_s_rd_dv", int'(s_rd_dv), 0);
    check("t7_s_rd_data", int'(s_rd_data), 0);
    check("t7_s_ovf", int'(s_ovf), 0);
    check("t7_s_unf", int'(s_unf), 0);
    check("t7_f_count", int'(f_count), 0);
    check("t7_f_empty", int'(f_empty), 1);
    check("t7_f_rd_dv", int'(f_rd_dv), 0);
    check("t7_f_rd_data", int'(f_rd_data), 0);
    wr_dv = 1'b0; rd_en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 8'h00, 0, 0);
    cyc(1, 8'h3C, 0, 0);
    repeat (3) cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
